// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
//  Module      : md_sched
//  Description : Multi-cycle multiply/divide scheduler with HI/LO ownership,
//                busy counter and D-stage stall request.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [2:0]  E_MDOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_is_md,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        stall_md
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [4:0] c_mult_cycles = 5'(MULT_CYCLES);
    localparam logic [4:0] c_div_cycles  = 5'(DIV_CYCLES);

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;

    logic [0:0]  r_state;
    logic [0:0]  w_next_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_start_ok;
    logic        w_is_mul;
    logic        w_done;
    logic        w_busy;

    assign w_start_ok = E_start && (E_MDOp >= c_op_mult) && (E_MDOp <= c_op_divu);
    assign w_is_mul   = (E_MDOp == c_op_mult) || (E_MDOp == c_op_multu);
    assign w_done     = (r_state == S_RUN) && (r_cnt == 5'd1);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next_state = S_RUN;
            S_RUN:   if (w_done)     w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        w_busy = (r_state == S_RUN);
    end

    assign busy     = w_busy;
    assign stall_md = D_is_md & (w_busy | E_start);
    assign HI       = r_hi;
    assign LO       = r_lo;

    // ---------------- result datapath (latched operands only) ----------------
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_b_nz;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_we;

    // Low 64 bits of the product of sign-extended operands is the signed product.
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Divisor forced non-zero; a zero divisor suppresses the write-back instead.
    assign w_b_nz   = (r_b == 32'd0) ? 32'd1 : r_b;
    assign w_a_mag  = r_a[31] ? (32'd0 - r_a) : r_a;
    assign w_b_mag  = w_b_nz[31] ? (32'd0 - w_b_nz) : w_b_nz;
    assign w_sq_mag = w_a_mag / w_b_mag;
    assign w_sr_mag = w_a_mag % w_b_mag;
    assign w_sq     = (r_a[31] ^ w_b_nz[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr     = r_a[31] ? (32'd0 - w_sr_mag) : w_sr_mag;
    assign w_uq     = r_a / w_b_nz;
    assign w_ur     = r_a % w_b_nz;

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        w_res_we = 1'b0;
        case (r_op)
            c_op_mult: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
                w_res_we = 1'b1;
            end
            c_op_multu: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
                w_res_we = 1'b1;
            end
            c_op_div: begin
                w_res_hi = w_sr;
                w_res_lo = w_sq;
                w_res_we = (r_b != 32'd0);
            end
            c_op_divu: begin
                w_res_hi = w_ur;
                w_res_lo = w_uq;
                w_res_we = (r_b != 32'd0);
            end
            default: begin
                w_res_we = 1'b0;
            end
        endcase
    end

    // ---------------- counter, operand latch and HI/LO ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 5'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_op  <= 3'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (w_start_ok) begin
                r_a   <= E_A;
                r_b   <= E_B;
                r_op  <= E_MDOp;
                r_cnt <= w_is_mul ? c_mult_cycles : c_div_cycles;
            end else if (E_MDOp == c_op_mthi) begin
                r_hi <= E_A;
            end else if (E_MDOp == c_op_mtlo) begin
                r_lo <= E_A;
            end
        end else begin
            r_cnt <= r_cnt - 5'd1;
            if (w_done && w_res_we) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_sched
//  Description : Self-checking bench for md_sched with a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_sched;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        E_start;
    logic [2:0]  E_MDOp;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_is_md;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        stall_md;

    int n_checks = 0;
    int n_fail   = 0;

    md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .E_start  (E_start),
        .E_MDOp   (E_MDOp),
        .E_A      (E_A),
        .E_B      (E_B),
        .D_is_md  (D_is_md),
        .busy     (busy),
        .HI       (HI),
        .LO       (LO),
        .stall_md (stall_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_rem;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_we;

    task automatic model_compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, prod;
        bit [63:0] ua, ub, uprod;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p_we = 1'b1;
        case (op)
            3'd1: begin prod = sa * sb; p_hi = prod[63:32]; p_lo = prod[31:0]; end
            3'd2: begin uprod = ua * ub; p_hi = uprod[63:32]; p_lo = uprod[31:0]; end
            3'd3: begin
                if (b == 32'd0) p_we = 1'b0;
                else begin q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0]; end
            end
            default: begin
                if (b == 32'd0) p_we = 1'b0;
                else begin uprod = ua / ub; p_lo = uprod[31:0]; uprod = ua % ub; p_hi = uprod[31:0]; end
            end
        endcase
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem = 0; m_hi = 32'd0; m_lo = 32'd0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0 && p_we) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (E_start && E_MDOp >= 3'd1 && E_MDOp <= 3'd4) begin
            model_compute(E_MDOp, E_A, E_B);
            m_rem = (E_MDOp <= 3'd2) ? MULT_N : DIV_N;
        end else if (E_MDOp == 3'd5) begin
            m_hi = E_A;
        end else if (E_MDOp == 3'd6) begin
            m_lo = E_A;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy",  {31'd0, busy}, {31'd0, (m_rem > 0)});
            chk("HI",    HI, m_hi);
            chk("LO",    LO, m_lo);
            chk("stall", {31'd0, stall_md}, {31'd0, D_is_md & ((m_rem > 0) | E_start)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        E_start = st; E_MDOp = op; E_A = a; E_B = b;
        step();
        E_start = 1'b0; E_MDOp = 3'd0; E_A = $urandom; E_B = $urandom;
    endtask

    task automatic run_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            step();
        end
    endtask

    int n;

    initial begin
        reset = 1'b1; E_start = 1'b0; E_MDOp = 3'd0; E_A = 32'd0; E_B = 32'd0; D_is_md = 1'b0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_HI", HI, 32'd0);
        chk("reset_LO", LO, 32'd0);
        #20 reset = 1'b0;

        // 1: signed mult
        issue(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0000_0003);
        run_busy(n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_HI", HI, 32'hFFFF_FFFF);
        chk("mult_LO", LO, 32'hFFFF_FFFD);

        // 2: unsigned mult
        issue(1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        run_busy(n);
        chk("multu_cycles", n, 32'd5);
        chk("multu_HI", HI, 32'h0000_0001);
        chk("multu_LO", LO, 32'hFFFF_FFFE);

        // 3: signed divide, overflow case, mixed signs, unsigned divide
        issue(1'b1, 3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        run_busy(n);
        chk("div_cycles", n, 32'd10);
        chk("div_LO", LO, 32'hFFFF_FFFD);
        chk("div_HI", HI, 32'hFFFF_FFFF);
        issue(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_busy(n);
        chk("divovf_LO", LO, 32'h8000_0000);
        chk("divovf_HI", HI, 32'h0000_0000);
        issue(1'b1, 3'd3, 32'h0000_0007, 32'hFFFF_FFFE);
        run_busy(n);
        chk("divneg_LO", LO, 32'hFFFF_FFFD);
        chk("divneg_HI", HI, 32'h0000_0001);
        issue(1'b1, 3'd4, 32'd100, 32'd7);
        run_busy(n);
        chk("divu_LO", LO, 32'd14);
        chk("divu_HI", HI, 32'd2);

        // 4: mthi/mtlo preload, divide by zero, mthi during RUN
        issue(1'b0, 3'd5, 32'h1234_5678, 32'd0);
        issue(1'b0, 3'd6, 32'h1234_5678, 32'd0);
        chk("mthi", HI, 32'h1234_5678);
        chk("mtlo", LO, 32'h1234_5678);
        issue(1'b1, 3'd4, 32'hAAAA_AAAA, 32'd0);
        issue(1'b0, 3'd5, 32'hDEAD_BEEF, 32'd0);
        run_busy(n);
        chk("div0_cycles", n + 1, 32'd10);
        chk("div0_HI", HI, 32'h1234_5678);
        chk("div0_LO", LO, 32'h1234_5678);

        // op 7 with start is a no-op
        issue(1'b1, 3'd7, 32'h1, 32'h1);
        chk("op7_busy", {31'd0, busy}, 32'd0);

        // 5: stall window across a mult start
        D_is_md = 1'b1; E_start = 1'b1; E_MDOp = 3'd1; E_A = 32'd2; E_B = 32'd3;
        #1;
        n = (stall_md === 1'b1) ? 1 : 0;
        @(negedge clk); #1;
        E_start = 1'b0; E_MDOp = 3'd0;
        while (stall_md === 1'b1 && n < 64) begin
            n++;
            step();
        end
        chk("stall_cycles", n, 32'd6);
        chk("stall_LO", LO, 32'd6);
        D_is_md = 1'b0;
        issue(1'b1, 3'd2, 32'd9, 32'd9);
        run_busy(n);
        chk("nostall_LO", LO, 32'd81);

        // 6: asynchronous reset mid-divide
        issue(1'b1, 3'd3, 32'h0000_0011, 32'h0000_0003);
        repeat (7) step();
        #2 reset = 1'b1;
        #1;
        chk("areset_busy", {31'd0, busy}, 32'd0);
        chk("areset_HI", HI, 32'd0);
        chk("areset_LO", LO, 32'd0);
        @(negedge clk); #1 reset = 1'b0;
        issue(1'b1, 3'd1, 32'd6, 32'd7);
        run_busy(n);
        chk("post_reset_cycles", n, 32'd5);
        chk("post_reset_LO", LO, 32'd42);
        chk("post_reset_HI", HI, 32'd0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
